ovl_unchange_stim_gen: RTL and testbench

//  Stimulus/response engine that drives the input side of an ovl_unchange checker.
//  Per request it opens one window: pulses start_event, holds test_expr stable for NUM_CKS

---
 rtl/ovl_unchange_stim_gen.sv | 164 ++++++++++++++++
 tb/tb_ovl_unchange_stim_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ovl_unchange_stim_gen.sv
// Stimulus/response engine for an ovl_unchange checker: opens one start_event window per
// request, optionally corrupts test_expr for one window cycle, and grades the checker's fire.
module ovl_unchange_stim_gen #(
  parameter int WIDTH     = 4,
  parameter int NUM_CKS   = 2,
  parameter int CHECK_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] hold_data,
  input  logic             inject_en,
  input  logic [7:0]       inject_cycle,
  input  logic [WIDTH-1:0] inject_data,
  input  logic             fire_in,
  output logic             enable,
  output logic             start_event,
  output logic [WIDTH-1:0] test_expr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fire_seen,
  output logic [7:0]       fire_cycle
);

  localparam int          LAST    = NUM_CKS + CHECK_LAT;
  localparam int          CW      = $clog2(LAST + 2);
  localparam logic [31:0] NCK_U   = 32'(NUM_CKS);
  localparam logic [31:0] LAST_U  = 32'(LAST);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WINDOW, S_CHECK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      cnt_w, cnt_dw;

  // Operands captured on the accepted go
  logic [WIDTH-1:0] hold_q, inj_data_q;
  logic             inj_en_q;
  logic [7:0]       inj_cyc_q;
  logic             exp_fire_q;

  logic             accept, sampling, corrupt;
  logic             start_event_d, busy_d, done_d, pass_d, fire_seen_d;
  logic [WIDTH-1:0] test_expr_d;
  logic [7:0]       fire_cycle_d;
  logic             exp_fire_in;

  assign accept   = (state_q == S_IDLE) && go;
  assign sampling = (state_q == S_START) || (state_q == S_WINDOW) || (state_q == S_CHECK);
  assign cnt_w    = 32'(cnt_q);
  assign cnt_dw   = 32'(cnt_d);

  // An out-of-range inject_cycle never lines up with a window count, so no corruption
  assign exp_fire_in = inject_en && (inject_cycle != 8'd0) && (32'(inject_cycle) <= NCK_U)
                       && (inject_data != hold_data);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start_event_d = 1'b0;
    done_d        = 1'b0;
    busy_d        = busy;
    pass_d        = pass;
    fire_seen_d   = fire_seen;
    fire_cycle_d  = fire_cycle;
    test_expr_d   = test_expr;
    corrupt       = 1'b0;

    if (sampling && fire_in && !fire_seen) begin
      fire_seen_d  = 1'b1;
      fire_cycle_d = (cnt_w > 32'd255) ? 8'hff : cnt_w[7:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d       = S_START;
          cnt_d         = '0;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          fire_seen_d   = 1'b0;
          fire_cycle_d  = 8'd0;
          start_event_d = 1'b1;
          test_expr_d   = hold_data;
        end
      end
      S_START: begin
        state_d = S_WINDOW;
        cnt_d   = CW'(1);
      end
      S_WINDOW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_w == NCK_U)
          state_d = (CHECK_LAT == 0) ? S_DONE : S_CHECK;
      end
      S_CHECK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_w == LAST_U)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Drive the registered outputs for the state being entered
    if (state_d == S_WINDOW) begin
      corrupt     = inj_en_q && (32'(inj_cyc_q) == cnt_dw);
      test_expr_d = corrupt ? inj_data_q : hold_q;
    end else if (state_d == S_CHECK) begin
      test_expr_d = hold_q;
    end else if (state_d == S_DONE) begin
      test_expr_d = hold_q;
      done_d      = 1'b1;
      busy_d      = 1'b0;
      pass_d      = (fire_seen_d == exp_fire_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      inj_data_q  <= '0;
      inj_en_q    <= 1'b0;
      inj_cyc_q   <= 8'd0;
      exp_fire_q  <= 1'b0;
      enable      <= 1'b0;
      start_event <= 1'b0;
      test_expr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fire_seen   <= 1'b0;
      fire_cycle  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      enable      <= 1'b1;
      start_event <= start_event_d;
      test_expr   <= test_expr_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      fire_seen   <= fire_seen_d;
      fire_cycle  <= fire_cycle_d;
      if (accept) begin
        hold_q     <= hold_data;
        inj_data_q <= inject_data;
        inj_en_q   <= inject_en;
        inj_cyc_q  <= inject_cycle;
        exp_fire_q <= exp_fire_in;
      end
    end
  end

endmodule

// File: tb/tb_ovl_unchange_stim_gen.sv
// Scoreboarded bench for ovl_unchange_stim_gen: directed cases plus randomized windows
// graded against a window-level reference model.
module tb_ovl_unchange_stim_gen;

  localparam int WIDTH     = 4;
  localparam int NUM_CKS   = 2;
  localparam int CHECK_LAT = 2;
  localparam int LAST      = NUM_CKS + CHECK_LAT;

  logic             clk = 1'b0;
  logic             reset, go, inject_en, fire_in;
  logic [WIDTH-1:0] hold_data, inject_data;
  logic [7:0]       inject_cycle;
  logic             enable, start_event, busy, done, pass, fire_seen;
  logic [WIDTH-1:0] test_expr;
  logic [7:0]       fire_cycle;

  ovl_unchange_stim_gen #(.WIDTH(WIDTH), .NUM_CKS(NUM_CKS), .CHECK_LAT(CHECK_LAT)) dut (
    .clk(clk), .reset(reset), .go(go), .hold_data(hold_data), .inject_en(inject_en),
    .inject_cycle(inject_cycle), .inject_data(inject_data), .fire_in(fire_in),
    .enable(enable), .start_event(start_event), .test_expr(test_expr), .busy(busy),
    .done(done), .pass(pass), .fire_seen(fire_seen), .fire_cycle(fire_cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       p;
    logic       fs;
    logic [7:0] fc;
  } res_t;

  res_t sb[$];
  res_t mon_r;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse retires one expected result
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got done=1 want no pending run (t=%0t)", $time);
      end else begin
        mon_r = sb.pop_front();
        chk("pass", 32'(pass), 32'(mon_r.p));
        chk("fire_seen", 32'(fire_seen), 32'(mon_r.fs));
        chk("fire_cycle", 32'(fire_cycle), 32'(mon_r.fc));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // One full window; fmask bit k drives fire_in during window offset k.
  task automatic run(input logic [3:0] h, input logic ie, input logic [7:0] ic,
                     input logic [3:0] id, input logic [31:0] fmask, input bit spam);
    res_t r;
    bit   corrupt;
    int   first;
    logic [3:0] exp_te;
    corrupt = ie && (ic >= 8'd1) && (int'(ic) <= NUM_CKS);
    first = -1;
    for (int k = 0; k <= LAST; k++)
      if (fmask[k] && first < 0) first = k;
    r.fs = (first >= 0);
    r.fc = (first >= 0) ? 8'(first) : 8'd0;
    r.p  = (r.fs == (corrupt && (id != h)));
    sb.push_back(r);

    hold_data = h; inject_en = ie; inject_cycle = ic; inject_data = id;
    go = 1'b1;
    @(posedge clk); #1;
    go = spam;
    for (int k = 0; k <= LAST + 1; k++) begin
      fire_in = fmask[k];
      exp_te  = (corrupt && k == int'(ic)) ? id : h;
      chk("start_event", 32'(start_event), 32'(k == 0));
      if (k <= LAST) chk("test_expr", 32'(test_expr), 32'(exp_te));
      chk("busy", 32'(busy), 32'(k <= LAST));
      chk("done", 32'(done), 32'(k == LAST + 1));
      @(posedge clk); #1;
    end
    go = 1'b0;
    fire_in = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_start", 32'(start_event), 32'd0);
    chk("pass_hold", 32'(pass), 32'(r.p));
    chk("fire_cycle_hold", 32'(fire_cycle), 32'(r.fc));
  endtask

  initial begin
    logic [3:0]  h, id;
    logic        ie;
    logic [7:0]  ic;
    logic [31:0] fm;

    reset = 1'b1; go = 1'b1; fire_in = 1'b0;
    hold_data = 4'h5; inject_en = 1'b1; inject_cycle = 8'd1; inject_data = 4'ha;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_start", 32'(start_event), 32'd0);
      chk("rst_test_expr", 32'(test_expr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_fire", 32'({fire_seen, fire_cycle}), 32'd0);
    end
    go = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    chk("enable_up", 32'(enable), 32'd1);
    chk("idle_after_rst", 32'(busy), 32'd0);

    run(4'h1, 1'b0, 8'd0, 4'h0, 32'h0, 1'b0);                 // clean window
    run(4'h1, 1'b1, 8'd1, 4'h2, 32'h1 << 2, 1'b0);            // corrupt, fire at 2
    run(4'h1, 1'b1, 8'd1, 4'h2, 32'h0, 1'b0);                 // missed fire
    run(4'h1, 1'b0, 8'd0, 4'h0, 32'h1 << 1, 1'b0);            // false fire
    run(4'h1, 1'b1, 8'd1, 4'h1, 32'h0, 1'b0);                 // inject equals hold
    run(4'h1, 1'b1, 8'd5, 4'h2, 32'h0, 1'b0);                 // out-of-range cycle
    run(4'h3, 1'b1, 8'd2, 4'h4, 32'h1 << LAST, 1'b0);         // fire in last check cycle
    run(4'h3, 1'b0, 8'd0, 4'h0, 32'h1 << (LAST + 1), 1'b0);   // fire in done cycle ignored
    run(4'h6, 1'b1, 8'd2, 4'h9, 32'h6, 1'b0);                 // first of several fires
    run(4'h2, 1'b1, 8'd2, 4'h8, 32'h1 << 3, 1'b1);            // go held high throughout

    // Reset in WINDOW cnt=1 aborts the run
    hold_data = 4'h7; inject_en = 1'b0; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    chk("mid_test_expr", 32'(test_expr), 32'h7);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_enable", 32'(enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_test_expr", 32'(test_expr), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_enable_up", 32'(enable), 32'd1);
    run(4'hc, 1'b1, 8'd1, 4'h3, 32'h1 << 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      h  = 4'($urandom_range(15));
      ie = 1'($urandom_range(1));
      ic = 8'($urandom_range(NUM_CKS + 2));
      id = ($urandom_range(3) == 0) ? h : 4'($urandom_range(15));
      if ($urandom_range(1) == 1)
        fm = (ie && ic >= 8'd1 && int'(ic) <= NUM_CKS && id != h) ? (32'h1 << (int'(ic) + 1)) : 32'h0;
      else
        fm = 32'($urandom_range((1 << (LAST + 2)) - 1));
      run(h, ie, ic, id, fm, 1'($urandom_range(1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
